// File: rtl/alu_seq_ctrl.sv
// ALU control decoder with an iterative shift-add multiplier and restoring divider.
// Optional define ALU_MUL_EARLY_TERM_EN: finish a multiply once no multiplier bits remain.
module alu_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [2:0]          opcode,
  input  logic [1:0]          funct2,
  input  logic [1:0]          ALUOp,
  input  logic [WIDTH-1:0]    src_a,
  input  logic [WIDTH-1:0]    src_b,
  output logic [ALUSEL_W-1:0] alu_sel,
  output logic                illegal_op,
  output logic                stall,
  output logic                mc_done,
  output logic [WIDTH-1:0]    mc_result,
  output logic                div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [ALUSEL_W-1:0] SEL_ADD  = ALUSEL_W'(0);
  localparam logic [ALUSEL_W-1:0] SEL_SUB  = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] SEL_MUL  = ALUSEL_W'(2);
  localparam logic [ALUSEL_W-1:0] SEL_DIV  = ALUSEL_W'(3);
  localparam logic [ALUSEL_W-1:0] SEL_AND  = ALUSEL_W'(4);
  localparam logic [ALUSEL_W-1:0] SEL_OR   = ALUSEL_W'(5);
  localparam logic [ALUSEL_W-1:0] SEL_SLLI = ALUSEL_W'(6);
  localparam logic [ALUSEL_W-1:0] SEL_SRLI = ALUSEL_W'(7);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [3:0] key;
  logic       dec_ok;
  logic       mc_op;

  assign key = {ALUOp, funct2};

  always_comb begin
    alu_sel    = SEL_ADD;
    illegal_op = 1'b0;
    dec_ok     = 1'b1;
    case (opcode)
      3'b000: begin
        case (key)
          4'b1000: alu_sel = SEL_ADD;
          4'b1001: alu_sel = SEL_SUB;
          4'b1010: alu_sel = SEL_MUL;
          4'b1011: alu_sel = SEL_DIV;
          default: dec_ok = 1'b0;
        endcase
      end
      3'b001: begin
        case (key)
          4'b1000: alu_sel = SEL_AND;
          4'b1001: alu_sel = SEL_OR;
          4'b1010: alu_sel = SEL_SUB;
          default: dec_ok = 1'b0;
        endcase
      end
      3'b010: begin
        case (key)
          4'b0000: alu_sel = SEL_ADD;
          4'b0001: alu_sel = SEL_SLLI;
          4'b0010: alu_sel = SEL_SRLI;
          default: dec_ok = 1'b0;
        endcase
      end
      3'b011, 3'b100: alu_sel = SEL_ADD;
      default: dec_ok = 1'b0;
    endcase
    if (!dec_ok) begin
      alu_sel    = SEL_ADD;
      illegal_op = valid_in;
    end
  end

  assign mc_op = valid_in & (opcode == 3'b000) & ((key == 4'b1010) | (key == 4'b1011));

  // a_q: multiplicand, or dividend shifting out while quotient bits shift in.
  // b_q: multiplier or divisor.  acc_q: product or partial remainder.
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] acc_step;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic             mul_last;

  assign acc_step = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh   = {acc_q, a_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, b_q};
  // Only used when rem_sh >= divisor, so the true difference fits in WIDTH bits.
  assign rem_sub  = rem_sh[WIDTH-1:0] - b_q;

`ifdef ALU_MUL_EARLY_TERM_EN
  assign mul_last = (cnt_q == CNT_W'(1)) || ((b_q >> 1) == '0);
`else
  assign mul_last = (cnt_q == CNT_W'(1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (mc_op) begin
          dz_d  = 1'b0;
          a_d   = src_a;
          b_d   = src_b;
          acc_d = '0;
          cnt_d = CNT_W'(WIDTH);
          if (!funct2[0]) begin
            state_d = S_MUL;
`ifdef ALU_MUL_EARLY_TERM_EN
            if (src_b == '0) begin
              state_d = S_DONE;
              res_d   = '0;
              cnt_d   = '0;
            end
`endif
          end else if (src_b == '0) begin
            state_d = S_DONE;
            res_d   = '1;
            dz_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_step;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (mul_last) begin
          state_d = S_DONE;
          res_d   = acc_step;
        end
      end
      S_DIV: begin
        acc_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          res_d   = {a_q[WIDTH-2:0], rem_ge};
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign stall     = ((state_q == S_IDLE) & mc_op) | (state_q == S_MUL) | (state_q == S_DIV);
  assign mc_done   = (state_q == S_DONE);
  assign mc_result = res_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: decode sweep, mul/div results and latency, reset abort.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [2:0]  opcode;
  logic [1:0]  funct2;
  logic [1:0]  ALUOp;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [2:0]  alu_sel;
  logic        illegal_op;
  logic        stall;
  logic        mc_done;
  logic [31:0] mc_result;
  logic        div_zero;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ALU_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  alu_seq_ctrl #(.WIDTH(32), .ALUSEL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .opcode     (opcode),
    .funct2     (funct2),
    .ALUOp      (ALUOp),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_sel    (alu_sel),
    .illegal_op (illegal_op),
    .stall      (stall),
    .mc_done    (mc_done),
    .mc_result  (mc_result),
    .div_zero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {illegal, sel} taken row by row from the decode table.
  function automatic logic [3:0] dec_exp(input logic [2:0] op, input logic [3:0] k);
    logic [3:0] r;
    r = 4'b1000;
    case (op)
      3'd0: case (k)
              4'b1000: r = 4'b0000;
              4'b1001: r = 4'b0001;
              4'b1010: r = 4'b0010;
              4'b1011: r = 4'b0011;
              default: r = 4'b1000;
            endcase
      3'd1: case (k)
              4'b1000: r = 4'b0100;
              4'b1001: r = 4'b0101;
              4'b1010: r = 4'b0001;
              default: r = 4'b1000;
            endcase
      3'd2: case (k)
              4'b0000: r = 4'b0000;
              4'b0001: r = 4'b0110;
              4'b0010: r = 4'b0111;
              default: r = 4'b1000;
            endcase
      3'd3, 3'd4: r = 4'b0000;
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

  task automatic run_op(input string tag, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_dz, input int exp_stall);
    int  stall_cycles;
    bit  done_seen;
    stall_cycles = 0;
    done_seen    = 1'b0;
    @(negedge clk);
    opcode   = 3'b000;
    ALUOp    = 2'b10;
    funct2   = {1'b1, is_div};
    src_a    = a;
    src_b    = b;
    valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (mc_done) begin
        done_seen = 1'b1;
        break;
      end
      if (stall) stall_cycles++;
      @(negedge clk);
    end
    $display("op %s a=%0h b=%0h result=%0h div_zero=%0b stall_cycles=%0d", tag, a, b,
             mc_result, div_zero, stall_cycles);
    chk({tag, "_done"}, done_seen, 1'b1);
    chk({tag, "_stall_cycles"}, stall_cycles, exp_stall);
    chk({tag, "_result"}, mc_result, exp_res);
    chk({tag, "_div_zero"}, div_zero, exp_dz);
    chk({tag, "_stall_in_done"}, stall, 1'b0);
    #1 valid_in = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, mc_done, 1'b0);
    chk({tag, "_idle_no_stall"}, stall, 1'b0);
    chk({tag, "_result_held"}, mc_result, exp_res);
  endtask

  initial begin
    logic [3:0] e;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    opcode   = 3'b000;
    funct2   = 2'b00;
    ALUOp    = 2'b00;
    src_a    = 32'd0;
    src_b    = 32'd0;
    #2;
    chk("reset_stall", stall, 1'b0);
    chk("reset_mc_done", mc_done, 1'b0);
    chk("reset_mc_result", mc_result, 32'd0);
    chk("reset_div_zero", div_zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        opcode   = 3'(op);
        ALUOp    = 2'(k >> 2);
        funct2   = 2'(k);
        src_b    = 32'd3;
        valid_in = 1'b1;
        e        = dec_exp(3'(op), 4'(k));
        #1;
        $display("decode op=%0d key=%04b alu_sel=%0d illegal=%0b stall=%0b", op, 4'(k),
                 alu_sel, illegal_op, stall);
        chk($sformatf("dec_sel_%0d_%0d", op, k), alu_sel, e[2:0]);
        chk($sformatf("dec_ill_%0d_%0d", op, k), illegal_op, e[3]);
        chk($sformatf("dec_stall_%0d_%0d", op, k), stall,
            (op == 0) && (k == 10 || k == 11));
        #1 valid_in = 1'b0;
      end
    end
    @(negedge clk);
    opcode = 3'b101;
    #1;
    chk("illegal_needs_valid", illegal_op, 1'b0);
    chk("no_accept_during_sweep", mc_done, 1'b0);

    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 32'd42, 1'b0, EARLY ? 4 : 33);
    run_op("mul_ovf", 1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, EARLY ? 3 : 33);
    run_op("div_zero", 1'b1, 32'd17, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run_op("div_5_9", 1'b1, 32'd5, 32'd9, 32'd0, 1'b0, 33);

    // Abort a long multiply partway through its iterations.
    @(negedge clk);
    opcode   = 3'b000;
    ALUOp    = 2'b10;
    funct2   = 2'b10;
    src_a    = 32'h1234_5678;
    src_b    = 32'hFFFF_FFFF;
    valid_in = 1'b1;
    for (int i = 0; i < 11; i++) @(negedge clk);
    #1;
    chk("pre_reset_stall", stall, 1'b1);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rst_mid_stall", stall, 1'b0);
    chk("rst_mid_mc_done", mc_done, 1'b0);
    chk("rst_mid_result", mc_result, 32'd0);
    chk("rst_mid_div_zero", div_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit done_after_rst;
      done_after_rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        #1;
        if (mc_done || stall) done_after_rst = 1'b1;
      end
      $display("reset abort: activity after reset=%0b", done_after_rst);
      chk("rst_no_done", done_after_rst, 1'b0);
    end

    run_op("mul_3x3", 1'b0, 32'd3, 32'd3, 32'd9, 1'b0, EARLY ? 3 : 33);
    run_op("mul_9x3", 1'b0, 32'd9, 32'd3, 32'd27, 1'b0, EARLY ? 3 : 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Parametrised successor to the single-cycle ALU control decoder for the multi-cycle core.
- Decodes opcode/funct2/ALUOp into the ALU select code and flags encodings outside the decode table.
- Executes mul and div in an internal iterative unit: shift-add multiply, restoring divide.
- Stalls the datapath while the iterative unit is running.
- Sits between the main control unit and the EX stage. The result is muxed onto the writeback path on mc_done.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
ALUSEL_W, 3, width of ALU select code

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
valid_in  in  1  instruction fields valid this cycle
opcode  in  3  instruction opcode
funct2  in  2  instruction funct2
ALUOp  in  2  ALU operation class from main control
src_a  in  WIDTH  operand A (multiplicand / dividend)
src_b  in  WIDTH  operand B (multiplier / divisor)
alu_sel  out  ALUSEL_W  ALU select for the single-cycle ALU
illegal_op  out  1  encoding outside the decode table
stall  out  1  hold PC/IF/ID; iterative op in progress
mc_done  out  1  one-cycle pulse, mc_result valid
mc_result  out  WIDTH  product low half or quotient
div_zero  out  1  last div had src_b==0; valid with mc_done

Behaviour:
- Decode is combinational on {ALUOp,funct2}. Codes: add 000, sub 001, mul 010, div 011, and 100, or 101, slli 110, srli 111.
  - opcode 000: 1000 add, 1001 sub, 1010 mul, 1011 div.
  - opcode 001: 1000 and, 1001 or, 1010 cmp -> sub.
  - opcode 010: 0000 addi -> add, 0001 slli, 0010 srli.
  - opcodes 011 and 100: add, for any ALUOp/funct2.
  - Any other combination: alu_sel=000, and illegal_op=valid_in.
  - alu_sel has no latches and is defined for all inputs.
- mc_op = valid_in & opcode==000 & {ALUOp,funct2} in {1010,1011}.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL on mc_op mul: latch src_a/src_b, clear accumulator, cnt=WIDTH.
  - IDLE -> DIV on mc_op div with src_b!=0: latch operands, clear remainder, cnt=WIDTH.
  - IDLE -> DONE on div with src_b==0: mc_result = all ones, div_zero=1.
  - MUL: one iteration per cycle; if multiplier LSB then acc+=multiplicand. Shift multiplicand left and multiplier right; cnt--. cnt reaching 0 -> DONE.
  - DIV: one restoring step per cycle: rem={rem,dividend MSB}; if rem>=divisor then rem-=divisor, q bit=1. cnt==0 -> DONE.
  - DONE: mc_done=1 for exactly one cycle, then -> IDLE unconditionally. The instruction still present on the inputs is not restarted.
- Arithmetic: unsigned, modulo 2^WIDTH. mul keeps the low WIDTH bits of the product. div returns the quotient only.
- stall = (state==IDLE & mc_op) | state==MUL | state==DIV. Deasserted in DONE.
- Latency: mul/div (nonzero divisor) stall for WIDTH+1 cycles; mc_done in the cycle after the last stall. Div by zero: 1 stall cycle.
- Non-mc instructions never assert stall.
- mc_result and div_zero hold their value until the next accept. div_zero is cleared on every accept.
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, cnt=0, mc_result=0, div_zero=0, mc_done=0, stall=0.
  - Operation is aborted; no mc_done pulse.
- valid_in deasserting while busy does not abort.

Optional Feature:
ALU_MUL_EARLY_TERM_EN
- Defined: in MUL, if the remaining multiplier is 0, go to DONE next cycle. Stall length = 1 + number of iterations up to and including the highest set multiplier bit (minimum 1).
- Undefined: mul always takes WIDTH iterations.
- Results are identical either way.

Test Plan:
- Decode sweep, all 3x2x2-bit combinations, valid_in=1 -> alu_sel per table; illegal_op=1 exactly on the unlisted ones (e.g. opcode 001 {11,11}, opcode 101); stall=0 except mul/div.
- mul, src_a=7, src_b=6, WIDTH=32 -> stall high 33 cycles; mc_done pulse; mc_result=42. Overflow case 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- div, src_a=100, src_b=7 -> mc_result=14, div_zero=0. src_a=5, src_b=9 -> 0. Stall 33 cycles.
- div, src_b=0 -> stall 1 cycle; next cycle mc_done=1, mc_result=0xFFFFFFFF, div_zero=1. State back in IDLE after that.
- rst_n pulsed low during MUL iteration 10 -> outputs 0 immediately, no mc_done. A fresh mul 3*3 afterwards gives 9.
- With ALU_MUL_EARLY_TERM_EN: mul 9*3 -> stall 3 cycles, mc_result=27. Without it: 33 cycles, same result.
